load_store_unit: RTL and testbench

// - Sits between the RISCV core's data port and dmem; replaces the direct single-cycle word port.
// - Accepts one load/store request at a time: byte (sb/lb/lbu), half (sh/lh/lhu) or word (sw/lw).
// - Drives a word-aligned memory request with byte enables, waits for mem_ack, and returns

---
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word core accesses into word-aligned memory requests with
// byte enables and a bounded wait. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       size_q;
    logic [1:0]       lane_q;
    logic             uns_q;
    logic             mem_req_q;
    logic             mem_we_q;
    logic [31:0]      mem_addr_q;
    logic [3:0]       mem_be_q;
    logic [31:0]      mem_wdata_q;
    logic             resp_valid_q;
    logic             resp_err_q;
    logic [31:0]      resp_rdata_q;

    logic [1:0]       lane_d;
    logic [3:0]       be_d;
    logic [31:0]      wdata_d;
    logic             err_d;
    logic [31:0]      shifted;
    logic [31:0]      load_data;
    logic             timeout_hit;

    // Lane is the naturally aligned byte offset; misaligned halves/words are folded down
    // unless trapping is enabled, in which case they are rejected before reaching memory.
    always_comb begin
        lane_d = req_addr[1:0];
        if (req_size == 2'b01) lane_d[0] = 1'b0;
        if (req_size == 2'b10) lane_d = 2'b00;
        case (req_size)
            2'b00:   begin be_d = 4'b0001 << lane_d;              wdata_d = {4{req_wdata[7:0]}};  end
            2'b01:   begin be_d = 4'b0011 << {lane_d[1], 1'b0};   wdata_d = {2{req_wdata[15:0]}}; end
            default: begin be_d = 4'b1111;                        wdata_d = req_wdata;            end
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        err_d = (req_size == 2'b11)
              || (req_size == 2'b01 && req_addr[0])
              || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
        err_d = (req_size == 2'b11);
`endif
    end

    always_comb begin
        shifted   = mem_rdata >> {lane_q, 3'b000};
        load_data = mem_rdata;
        case (size_q)
            2'b00:   load_data = {{24{shifted[7]  & ~uns_q}}, shifted[7:0]};
            2'b01:   load_data = {{16{shifted[15] & ~uns_q}}, shifted[15:0]};
            default: load_data = mem_rdata;
        endcase
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Response outputs default low every cycle so resp_valid is a single-cycle pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            size_q       <= 2'b00;
            lane_q       <= 2'b00;
            uns_q        <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (req_valid) begin
                        if (err_d) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else begin
                            state_q     <= REQ;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= req_we;
                            mem_addr_q  <= {req_addr[31:2], 2'b00};
                            mem_be_q    <= be_d;
                            mem_wdata_q <= wdata_d;
                            size_q      <= req_size;
                            lane_q      <= lane_d;
                            uns_q       <= req_unsigned;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state_q      <= RESP;
                        mem_req_q    <= 1'b0;
                        cnt_q        <= '0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= mem_we_q ? 32'h0 : load_data;
                    end else if (timeout_hit) begin
                        state_q      <= RESP;
                        mem_req_q    <= 1'b0;
                        cnt_q        <= '0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE) && reset;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit: hand-computed vectors for loads, stores,
// timeout, illegal/misaligned accesses and asynchronous reset.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checkCount = 0;
    int passCount  = 0;

    load_store_unit #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for one edge; returns 1 ns into the cycle after the accept edge.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        tick();
        req_valid    = 1'b0;
    endtask

    task automatic runAccess(input string tag, input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                             input int waitCycles, input logic [31:0] expAddr, input logic [3:0] expBe,
                             input logic [31:0] expWdata, input logic [31:0] expRdata);
        applyStimulus(we, size, uns, addr, wdata);
        checkOutput({tag, ".mem_req"}, 32'(mem_req), 32'd1);
        checkOutput({tag, ".mem_we"}, 32'(mem_we), 32'(we));
        checkOutput({tag, ".mem_addr"}, mem_addr, expAddr);
        checkOutput({tag, ".mem_be"}, 32'(mem_be), 32'(expBe));
        if (we) checkOutput({tag, ".mem_wdata"}, mem_wdata, expWdata);
        for (int i = 0; i < waitCycles; i++) begin
            tick();
            checkOutput({tag, ".mem_req_held"}, 32'(mem_req), 32'd1);
            checkOutput({tag, ".no_early_resp"}, 32'(resp_valid), 32'd0);
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        checkOutput({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
        checkOutput({tag, ".resp_err"}, 32'(resp_err), 32'd0);
        checkOutput({tag, ".resp_rdata"}, resp_rdata, expRdata);
        checkOutput({tag, ".mem_req_drop"}, 32'(mem_req), 32'd0);
        tick();
        checkOutput({tag, ".resp_pulse"}, 32'(resp_valid), 32'd0);
        checkOutput({tag, ".ready_again"}, 32'(req_ready), 32'd1);
        checkOutput({tag, ".rdata_idle"}, resp_rdata, 32'd0);
    endtask

    initial begin
        reset        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        mem_ack      = 1'b0;
        mem_rdata    = 32'h0;
        tick();
        tick();
        checkOutput("reset.req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset.mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset.resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset.mem_addr", mem_addr, 32'd0);
        checkOutput("reset.mem_be", 32'(mem_be), 32'd0);
        reset = 1'b1;
        tick();
        checkOutput("release.req_ready", 32'(req_ready), 32'd1);

        runAccess("lbu1003", 1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 32'h80AB_CDEF, 0,
                  32'h0000_1000, 4'b1000, 32'h0, 32'h0000_0080);
        runAccess("lh2002", 1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_1234, 0,
                  32'h0000_2000, 4'b1100, 32'h0, 32'hFFFF_8001);
        runAccess("lhu2002", 1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_1234, 0,
                  32'h0000_2000, 4'b1100, 32'h0, 32'h0000_8001);
        runAccess("sb3001", 1'b1, 2'b00, 1'b0, 32'h0000_3001, 32'h1234_56A5, 32'hFFFF_FFFF, 3,
                  32'h0000_3000, 4'b0010, 32'hA5A5_A5A5, 32'h0);
        runAccess("sh0006", 1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'hDEAD_BEEF, 32'h0, 1,
                  32'h0000_0004, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        runAccess("lb0001", 1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'h0, 32'h0000_F700, 0,
                  32'h0000_0000, 4'b0010, 32'h0, 32'hFFFF_FFF7);
        runAccess("sw0010", 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 0,
                  32'h0000_0010, 4'b1111, 32'hCAFE_F00D, 32'h0);

        // No ack: 16 REQ cycles, then an error response.
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0);
        for (int i = 0; i < 16; i++) begin
            checkOutput("timeout.mem_req_held", 32'(mem_req), 32'd1);
            tick();
        end
        checkOutput("timeout.mem_req", 32'(mem_req), 32'd0);
        checkOutput("timeout.resp_valid", 32'(resp_valid), 32'd1);
        checkOutput("timeout.resp_err", 32'(resp_err), 32'd1);
        checkOutput("timeout.resp_rdata", resp_rdata, 32'd0);
        tick();
        runAccess("lw_after_to", 1'b0, 2'b10, 1'b0, 32'h0000_5004, 32'h0, 32'h1122_3344, 0,
                  32'h0000_5004, 4'b1111, 32'h0, 32'h1122_3344);
        // Ack in the very cycle the timeout would fire: ack wins.
        runAccess("ack_at_limit", 1'b0, 2'b10, 1'b0, 32'h0000_5008, 32'h0, 32'h5566_7788, 15,
                  32'h0000_5008, 4'b1111, 32'h0, 32'h5566_7788);

`ifdef LSU_MISALIGN_TRAP_EN
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_4002, 32'h0);
        checkOutput("mis.mem_req", 32'(mem_req), 32'd0);
        checkOutput("mis.resp_valid", 32'(resp_valid), 32'd1);
        checkOutput("mis.resp_err", 32'(resp_err), 32'd1);
        tick();
        checkOutput("mis.resp_pulse", 32'(resp_valid), 32'd0);
        checkOutput("mis.mem_req_after", 32'(mem_req), 32'd0);
`else
        runAccess("lw4002", 1'b0, 2'b10, 1'b0, 32'h0000_4002, 32'h0, 32'h0BAD_F00D, 0,
                  32'h0000_4000, 4'b1111, 32'h0, 32'h0BAD_F00D);
`endif

        applyStimulus(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0);
        checkOutput("illegal.mem_req", 32'(mem_req), 32'd0);
        checkOutput("illegal.resp_valid", 32'(resp_valid), 32'd1);
        checkOutput("illegal.resp_err", 32'(resp_err), 32'd1);
        tick();
        checkOutput("illegal.ready", 32'(req_ready), 32'd1);

        // Stray ack while idle.
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checkOutput("idle_ack.resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("idle_ack.mem_req", 32'(mem_req), 32'd0);

        // A second request while busy is ignored.
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0000_7000;
        checkOutput("busy.req_ready", 32'(req_ready), 32'd0);
        tick();
        req_valid = 1'b0;
        checkOutput("busy.mem_addr", mem_addr, 32'h0000_6000);
        checkOutput("busy.mem_we", 32'(mem_we), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hA1B2_C3D4;
        tick();
        mem_ack   = 1'b0;
        checkOutput("busy.resp_rdata", resp_rdata, 32'hA1B2_C3D4);
        tick();
        checkOutput("busy.no_second", 32'(mem_req), 32'd0);

        // Reset during REQ discards the access.
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_8000, 32'h0);
        checkOutput("rst.mem_req_before", 32'(mem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("rst.mem_req_async", 32'(mem_req), 32'd0);
        checkOutput("rst.req_ready_low", 32'(req_ready), 32'd0);
        tick();
        reset = 1'b1;
        #1;
        checkOutput("rst.req_ready", 32'(req_ready), 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checkOutput("rst.stale_ack_resp", 32'(resp_valid), 32'd0);
        checkOutput("rst.stale_ack_req", 32'(mem_req), 32'd0);
        tick();
        checkOutput("rst.no_resp", 32'(resp_valid), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
